// File: rtl/vlc_pkg.sv
// Shared types and constants for the AC run/level sequencer.
package vlc_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    EMIT_RUN   = 2'd1,
    EMIT_LEVEL = 2'd2
  } vlc_state_e;

  // Adaptation history at the start of every block.
  localparam int PREV_RUN_INIT = 4;
  localparam int PREV_LVL_INIT = 1;

  // Golomb parameter thresholds on the previous run/level.
  localparam int K_THR_LO = 1;
  localparam int K_THR_HI = 3;

  // Pipeline depth of the external exp-Golomb codeword unit.
  localparam int CW_LATENCY = 2;

  // Qualifiers that travel alongside a request through the codeword unit.
  typedef struct packed {
    logic valid;
    logic is_level;
    logic last;
    logic done;
  } vlc_tag_t;

  // Map a previous run or level magnitude onto the Golomb parameter k.
  function automatic logic [2:0] k_sel(input logic [31:0] prev);
    if (prev <= 32'(K_THR_LO))      return 3'd0;
    else if (prev <= 32'(K_THR_HI)) return 3'd1;
    else                            return 3'd2;
  endfunction

endpackage

// File: rtl/vlc_tag_delay.sv
// Fixed-depth shift register re-timing request tags across the codeword unit.
module vlc_tag_delay
  import vlc_pkg::*;
#(
  parameter int DEPTH = CW_LATENCY
) (
  input  logic     clk,
  input  logic     reset_n,
  input  vlc_tag_t tag_in,
  output vlc_tag_t tag_out
);

  vlc_tag_t pipe_q [DEPTH];
  vlc_tag_t pipe_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the fresh tag.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Tag stages; reset drops every in-flight tag so nothing stale is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/vlc_ac_run_level_sched.sv
// AC run/level sequencer: scans one block of coefficients, emits run and
// level requests with adaptive k, and re-times qualifiers for the bit packer.
module vlc_ac_run_level_sched
  import vlc_pkg::*;
#(
  parameter int COEF_W  = 12,
  parameter int RUN_MAX = 63
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_last,
  output logic [31:0]              req_val,
  output logic [2:0]               req_k,
  output logic [1:0]               req_is_add_setbit,
  output logic                     req_is_ac_level,
  output logic                     req_is_ac_minus_n,
  output logic                     req_valid,
  output logic                     cw_valid,
  output logic                     cw_is_level,
  output logic                     cw_last,
  output logic                     blk_done
);

  localparam int RUN_W = $clog2(RUN_MAX + 1);
  // One extra bit so |most negative| is representable.
  localparam int ABS_W = COEF_W + 1;

  vlc_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [RUN_W-1:0] prev_run_q, prev_run_d;
  logic [ABS_W-1:0] prev_lvl_q, prev_lvl_d;
  logic             null_q, null_d;

  logic [ABS_W-1:0] abs_q, abs_d;
  logic             sign_q, sign_d;
  logic             last_q, last_d;

  logic signed [ABS_W-1:0] coef_ext;
  logic [ABS_W-1:0]        coef_abs;
  logic                    req_last;
  vlc_tag_t                tag_in, tag_out;

  // Magnitude and sign of the incoming coefficient, widened before negation.
  always_comb begin
    coef_ext = {coef_data[COEF_W-1], coef_data};
    coef_abs = coef_data[COEF_W-1] ? $unsigned(-coef_ext) : $unsigned(coef_ext);
  end

  // Next-state, adaptation history and request outputs.
  always_comb begin
    state_d           = state_q;
    run_cnt_d         = run_cnt_q;
    prev_run_d        = prev_run_q;
    prev_lvl_d        = prev_lvl_q;
    null_d            = 1'b0;
    abs_d             = abs_q;
    sign_d            = sign_q;
    last_d            = last_q;
    coef_ready        = 1'b0;
    req_valid         = 1'b0;
    req_val           = '0;
    req_k             = '0;
    req_is_add_setbit = 2'b00;
    req_is_ac_level   = 1'b0;
    req_is_ac_minus_n = 1'b0;
    req_last          = 1'b0;

    unique case (state_q)
      SCAN: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          if (coef_data == '0) begin
            if (coef_last) begin
              // Trailing zeros are dropped; a null tag still signals block end.
              run_cnt_d  = '0;
              prev_run_d = RUN_W'(PREV_RUN_INIT);
              prev_lvl_d = ABS_W'(PREV_LVL_INIT);
              null_d     = 1'b1;
            end else if (run_cnt_q != RUN_W'(RUN_MAX)) begin
              run_cnt_d = run_cnt_q + RUN_W'(1);
            end
          end else begin
            abs_d   = coef_abs;
            sign_d  = coef_data[COEF_W-1];
            last_d  = coef_last;
            state_d = EMIT_RUN;
          end
        end
      end

      EMIT_RUN: begin
        req_valid  = 1'b1;
        req_val    = 32'(run_cnt_q);
        req_k      = k_sel(32'(prev_run_q));
        prev_run_d = run_cnt_q;
        run_cnt_d  = '0;
        state_d    = EMIT_LEVEL;
      end

      EMIT_LEVEL: begin
        req_valid         = 1'b1;
        req_val           = 32'(abs_q - ABS_W'(1));
        req_k             = k_sel(32'(prev_lvl_q));
        req_is_ac_level   = 1'b1;
        req_is_ac_minus_n = sign_q;
        req_last          = last_q;
        prev_lvl_d        = abs_q;
        if (last_q) begin
          prev_run_d = RUN_W'(PREV_RUN_INIT);
          prev_lvl_d = ABS_W'(PREV_LVL_INIT);
        end
        state_d = SCAN;
      end

      default: state_d = SCAN;
    endcase
  end

  // Control state and adaptation history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCAN;
      run_cnt_q  <= '0;
      prev_run_q <= RUN_W'(PREV_RUN_INIT);
      prev_lvl_q <= ABS_W'(PREV_LVL_INIT);
      null_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      prev_run_q <= prev_run_d;
      prev_lvl_q <= prev_lvl_d;
      null_q     <= null_d;
    end
  end

  // Latched coefficient payload; only read while a request is being issued.
  always_ff @(posedge clk) begin
    abs_q  <= abs_d;
    sign_q <= sign_d;
    last_q <= last_d;
  end

  // Tags enter alongside the request (or as a null tag) and exit with the codeword.
  always_comb begin
    tag_in.valid    = req_valid;
    tag_in.is_level = req_is_ac_level;
    tag_in.last     = req_last;
    tag_in.done     = req_last | null_q;
  end

  vlc_tag_delay #(
    .DEPTH (CW_LATENCY)
  ) u_tag_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign cw_valid    = tag_out.valid;
  assign cw_is_level = tag_out.is_level;
  assign cw_last     = tag_out.last;
  assign blk_done    = tag_out.done;

endmodule

// File: tb/tb_vlc_ac_run_level_sched.sv
// Bench for the AC run/level sequencer: cycle-indexed expectation model plus
// literal pins on the captured request stream.
module tb_vlc_ac_run_level_sched;

  logic               clk;
  logic               reset_n;
  logic               coef_valid;
  logic               coef_ready;
  logic signed [11:0] coef_data;
  logic               coef_last;
  logic [31:0]        req_val;
  logic [2:0]         req_k;
  logic [1:0]         req_is_add_setbit;
  logic               req_is_ac_level;
  logic               req_is_ac_minus_n;
  logic               req_valid;
  logic               cw_valid;
  logic               cw_is_level;
  logic               cw_last;
  logic               blk_done;

  vlc_ac_run_level_sched #(
    .COEF_W  (12),
    .RUN_MAX (63)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .coef_valid        (coef_valid),
    .coef_ready        (coef_ready),
    .coef_data         (coef_data),
    .coef_last         (coef_last),
    .req_val           (req_val),
    .req_k             (req_k),
    .req_is_add_setbit (req_is_add_setbit),
    .req_is_ac_level   (req_is_ac_level),
    .req_is_ac_minus_n (req_is_ac_minus_n),
    .req_valid         (req_valid),
    .cw_valid          (cw_valid),
    .cw_is_level       (cw_is_level),
    .cw_last           (cw_last),
    .blk_done          (blk_done)
  );

  typedef struct {
    int val;
    int k;
    bit lvl;
    bit neg;
  } req_t;

  typedef struct {
    bit lvl;
    bit last;
  } cw_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   chk_en = 0;

  // Expectations keyed by the cycle in which they must be visible.
  req_t exp_req  [int];
  cw_t  exp_cw   [int];
  bit   exp_done [int];
  bit   exp_busy [int];

  // Block-level model state.
  int m_run;
  int m_prev_run;
  int m_prev_lvl;

  req_t req_log [$];
  int   last_acc;
  int   last_done_cyc;
  req_t ce;
  cw_t  cc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int kfn(input int prev);
    if (prev <= 1) return 0;
    if (prev <= 3) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_run      = 0;
    m_prev_run = 4;
    m_prev_lvl = 1;
    exp_req.delete();
    exp_cw.delete();
    exp_done.delete();
    exp_busy.delete();
  endtask

  // What the block must produce once coefficient c is accepted at cycle t.
  task automatic model_accept(input int c, input bit last, input int t);
    int a;
    last_acc = t;
    if (c == 0) begin
      if (last) begin
        m_run = 0; m_prev_run = 4; m_prev_lvl = 1;
        exp_done[t+3] = 1'b1;
      end else if (m_run < 63) begin
        m_run++;
      end
    end else begin
      a = (c < 0) ? -c : c;
      exp_req[t+1] = '{val: m_run, k: kfn(m_prev_run), lvl: 1'b0, neg: 1'b0};
      exp_req[t+2] = '{val: a - 1, k: kfn(m_prev_lvl), lvl: 1'b1, neg: (c < 0)};
      exp_cw[t+3]  = '{lvl: 1'b0, last: 1'b0};
      exp_cw[t+4]  = '{lvl: 1'b1, last: last};
      exp_busy[t+1] = 1'b1;
      exp_busy[t+2] = 1'b1;
      m_prev_run = m_run;
      m_run      = 0;
      m_prev_lvl = a;
      if (last) begin
        exp_done[t+4] = 1'b1;
        m_prev_run = 4; m_prev_lvl = 1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (req_valid)
        req_log.push_back('{val: int'(req_val), k: int'(req_k),
                            lvl: req_is_ac_level, neg: req_is_ac_minus_n});
      if (exp_req.exists(cyc)) begin
        ce = exp_req[cyc];
        exp_req.delete(cyc);
        chk("req", 64'({req_valid, req_is_add_setbit, req_is_ac_level, req_is_ac_minus_n, req_k, req_val}),
            64'({1'b1, 2'b00, ce.lvl, ce.neg, 3'(ce.k), 32'(ce.val)}));
      end else begin
        chk("req_idle", 64'({req_valid, req_is_add_setbit, req_is_ac_level, req_is_ac_minus_n, req_k, req_val}),
            64'(0));
      end
      if (exp_cw.exists(cyc)) begin
        cc = exp_cw[cyc];
        exp_cw.delete(cyc);
        chk("cw", 64'({cw_valid, cw_is_level, cw_last}), 64'({1'b1, cc.lvl, cc.last}));
      end else begin
        chk("cw_idle", 64'({cw_valid, cw_is_level, cw_last}), 64'(0));
      end
      chk("blk_done", 64'(blk_done), 64'(exp_done.exists(cyc) != 0));
      if (exp_done.exists(cyc)) exp_done.delete(cyc);
      chk("coef_ready", 64'(coef_ready), 64'(exp_busy.exists(cyc) == 0));
      if (exp_busy.exists(cyc)) exp_busy.delete(cyc);
      if (blk_done) last_done_cyc = cyc;
    end
  end

  // Offer one coefficient from a falling edge; returns on the falling edge after acceptance.
  task automatic send(input int c, input bit last);
    int guard;
    guard = 0;
    coef_valid = 1'b1;
    coef_data  = 12'(c);
    coef_last  = last;
    while (!coef_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!coef_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout cyc=%0d got=ready0 want=ready1", cyc);
      coef_valid = 1'b0;
      return;
    end
    model_accept(c, last, cyc);
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    coef_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic req_t log_at(input int i);
    req_t r;
    r = '{val: -1, k: -1, lvl: 1'b0, neg: 1'b0};
    if (i < req_log.size()) r = req_log[i];
    return r;
  endfunction

  task automatic pin(input string name, input int i, input int val, input int k,
                     input bit lvl, input bit neg);
    req_t r;
    r = log_at(i);
    chk(name, 64'({r.val, 3'(r.k), r.lvl, r.neg}), 64'({val, 3'(k), lvl, neg}));
  endtask

  task automatic check_rst(input string name);
    chk({name, "_ready"}, 64'(coef_ready), 64'(1));
    chk({name, "_req"}, 64'({req_valid, req_is_add_setbit, req_is_ac_level, req_is_ac_minus_n, req_k, req_val}),
        64'(0));
    chk({name, "_tags"}, 64'({cw_valid, cw_is_level, cw_last, blk_done}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    coef_valid = 1'b0;
    coef_data  = '0;
    coef_last  = 1'b0;
    last_acc   = 0;
    last_done_cyc = -100;
    model_reset();
    idle(3);
    check_rst("reset");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    idle(1);

    // Mixed block ending in a zero.
    req_log.delete();
    send(5, 0); send(0, 0); send(0, 0); send(-3, 0); send(0, 1);
    idle(6);
    chk("t1_count", 64'(req_log.size()), 64'(4));
    pin("t1_run0", 0, 0, 2, 1'b0, 1'b0);
    pin("t1_lvl0", 1, 4, 0, 1'b1, 1'b0);
    pin("t1_run1", 2, 2, 0, 1'b0, 1'b0);
    pin("t1_lvl1", 3, 2, 2, 1'b1, 1'b1);
    chk("t1_done_lat", 64'(last_done_cyc - last_acc), 64'(3));

    // All-zero block.
    req_log.delete();
    for (int i = 0; i < 62; i++) send(0, 0);
    send(0, 1);
    idle(6);
    chk("t2_count", 64'(req_log.size()), 64'(0));
    chk("t2_done_lat", 64'(last_done_cyc - last_acc), 64'(3));

    // Most negative coefficient as the only (and last) symbol.
    req_log.delete();
    send(-2048, 1);
    idle(6);
    chk("t3_count", 64'(req_log.size()), 64'(2));
    pin("t3_run", 0, 0, 2, 1'b0, 1'b0);
    pin("t3_lvl", 1, 2047, 0, 1'b1, 1'b1);
    chk("t3_done_lat", 64'(last_done_cyc - last_acc), 64'(4));

    // Run counter saturation.
    req_log.delete();
    for (int i = 0; i < 70; i++) send(0, 0);
    send(1, 1);
    idle(6);
    chk("t4_count", 64'(req_log.size()), 64'(2));
    pin("t4_run", 0, 63, 2, 1'b0, 1'b0);
    pin("t4_lvl", 1, 0, 0, 1'b1, 1'b0);

    // Reset between the run and level requests.
    send(7, 0);
    #1;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    model_reset();
    #1;
    check_rst("midrst");
    idle(2);
    check_rst("midrst_hold");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    req_log.delete();
    idle(4);
    send(2, 1);
    idle(6);
    chk("t5_count", 64'(req_log.size()), 64'(2));
    pin("t5_run", 0, 0, 2, 1'b0, 1'b0);
    pin("t5_lvl", 1, 1, 0, 1'b1, 1'b0);

    // Back-to-back blocks, the second starting while the first drains.
    req_log.delete();
    send(0, 0); send(9, 1);
    send(1, 0); send(4, 1);
    idle(6);
    chk("t6_count", 64'(req_log.size()), 64'(6));
    pin("t6_a_run", 0, 1, 2, 1'b0, 1'b0);
    pin("t6_a_lvl", 1, 8, 0, 1'b1, 1'b0);
    pin("t6_b_run0", 2, 0, 2, 1'b0, 1'b0);
    pin("t6_b_lvl0", 3, 0, 0, 1'b1, 1'b0);
    pin("t6_b_run1", 4, 0, 0, 1'b0, 1'b0);
    pin("t6_b_lvl1", 5, 3, 0, 1'b1, 1'b0);

    chk("drain", 64'(exp_req.num() + exp_cw.num() + exp_done.num() + exp_busy.num()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
